// File: rtl/fm_meas_ctrl_if.sv
// Bundle between the FM demodulator output path and the measurement sequencer.
// Latency: none, wires only.
// Backpressure: none; master drives the stimulus and reads the results, slave is the sequencer.
interface fm_meas_ctrl_if;
    logic        start;
    logic        cont;
    logic        sample_valid;
    logic [9:0]  demod_in;
    logic        busy;
    logic        result_valid;
    logic [12:0] mod_freq;
    logic [15:0] delta_f;
    logic [7:0]  mf;

    modport master (
        output start, cont, sample_valid, demod_in,
        input  busy, result_valid, mod_freq, delta_f, mf
    );

    modport slave (
        input  start, cont, sample_valid, demod_in,
        output busy, result_valid, mod_freq, delta_f, mf
    );
endinterface

// File: rtl/fm_meas_ctrl.sv
// FM measurement sequencer: windowed hysteretic zero-crossing count, peak deviation, serial mf divide.
// Latency: start to result_valid = 1+SETTLE_CYC+WIN_CYC+17 clk_32m cycles; result_valid is one cycle.
// Backpressure: none, start ignored while busy. Macro FM_AVG_EN: publish 4-window running averages.
module fm_meas_ctrl #(
    parameter int SETTLE_CYC = 256,
    parameter int WIN_CYC    = 3200000,
    parameter int FREQ_SCALE = 10,
    parameter int HYST       = 8,
    parameter int KDF        = 20
) (
    input  logic          clk_32m,
    input  logic          rst_n,
    fm_meas_ctrl_if.slave bus
);
    localparam int CNT_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int CW      = ($clog2(CNT_MAX + 1) < 5) ? 5 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SET_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CW-1:0] WIN_LAST = CW'(WIN_CYC - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(16);
    localparam logic [9:0]    LO_TH    = 10'(512 - HYST);
    localparam logic [9:0]    HI_TH    = 10'(512 + HYST);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACQ, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [15:0]     xcnt_q, xcnt_d;
    logic            armed_q, armed_d;
    logic [9:0]      maxv_q, maxv_d, minv_q, minv_d;
    logic            any_valid_q, any_valid_d;
    logic [12:0]     frq_q, frq_d;        // published f, also the divisor
    logic [15:0]     dev_q, dev_d;        // published d
    logic [12:0]     rem_q, rem_d;
    logic [15:0]     quo_q, quo_d;
    logic [12:0]     mod_freq_q, mod_freq_d;
    logic [15:0]     delta_f_q, delta_f_d;
    logic [7:0]      mf_q, mf_d;

    logic [31:0]     prod_f, prod_d;
    logic [12:0]     f_w, f_pub;
    logic [15:0]     d_w, d_pub;
    logic [9:0]      vpp;
    logic [13:0]     rem_sh, rem_diff;
    logic [12:0]     rem_nx;
    logic [15:0]     quo_nx;
    logic            enter_acq;
`ifdef FM_AVG_EN
    logic [12:0]     hf_q [0:2];
    logic [12:0]     hf_d [0:2];
    logic [15:0]     hd_q [0:2];
    logic [15:0]     hd_d [0:2];
    logic [14:0]     sum_f;
    logic [17:0]     sum_d;
`endif

    // Next-state, datapath and divider step; every target defaults to hold.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        xcnt_d      = xcnt_q;
        armed_d     = armed_q;
        maxv_d      = maxv_q;
        minv_d      = minv_q;
        any_valid_d = any_valid_q;
        frq_d       = frq_q;
        dev_d       = dev_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        mod_freq_d  = mod_freq_q;
        delta_f_d   = delta_f_q;
        mf_d        = mf_q;
        enter_acq   = 1'b0;

        // Per-window results from the accumulators, saturated to the output widths.
        prod_f = 32'(xcnt_q) * 32'(FREQ_SCALE);
        f_w    = (prod_f > 32'd8191) ? 13'd8191 : prod_f[12:0];
        vpp    = any_valid_q ? (maxv_q - minv_q) : 10'd0;
        prod_d = (32'(KDF) * {22'd0, vpp}) >> 1;
        d_w    = (prod_d > 32'd65535) ? 16'hFFFF : prod_d[15:0];

`ifdef FM_AVG_EN
        for (int i = 0; i < 3; i++) begin
            hf_d[i] = hf_q[i];
            hd_d[i] = hd_q[i];
        end
        sum_f = 15'(hf_q[0]) + 15'(hf_q[1]) + 15'(hf_q[2]) + 15'(f_w);
        sum_d = 18'(hd_q[0]) + 18'(hd_q[1]) + 18'(hd_q[2]) + 18'(d_w);
        f_pub = 13'(sum_f >> 2);
        d_pub = 16'(sum_d >> 2);
`else
        f_pub = f_w;
        d_pub = d_w;
`endif

        // One restoring-division step: dividend bits shift out of quo_q MSB first.
        rem_sh   = {rem_q, quo_q[15]};
        rem_diff = rem_sh - {1'b0, frq_q};
        if (rem_sh >= {1'b0, frq_q}) begin
            rem_nx = rem_diff[12:0];
            quo_nx = {quo_q[14:0], 1'b1};
        end else begin
            rem_nx = rem_sh[12:0];
            quo_nx = {quo_q[14:0], 1'b0};
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cyc_d = '0;
`ifdef FM_AVG_EN
                    for (int i = 0; i < 3; i++) begin
                        hf_d[i] = '0;
                        hd_d[i] = '0;
                    end
`endif
                    if (SETTLE_CYC == 0) begin
                        state_d   = S_ACQ;
                        enter_acq = 1'b1;
                    end else begin
                        state_d   = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (cyc_q == SET_LAST) begin
                    state_d   = S_ACQ;
                    enter_acq = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_ACQ: begin
                if (bus.sample_valid) begin
                    any_valid_d = 1'b1;
                    if (bus.demod_in > maxv_q) maxv_d = bus.demod_in;
                    if (bus.demod_in < minv_q) minv_d = bus.demod_in;
                    if (bus.demod_in < LO_TH) begin
                        armed_d = 1'b1;
                    end else if (armed_q && (bus.demod_in >= HI_TH)) begin
                        armed_d = 1'b0;
                        if (xcnt_q != 16'hFFFF) xcnt_d = xcnt_q + 1'b1;
                    end
                end
                if (cyc_q == WIN_LAST) begin
                    state_d = S_DIV;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DIV: begin
                if (cyc_q == '0) begin
                    // Latch the window results and load the divider.
                    frq_d = f_pub;
                    dev_d = d_pub;
                    rem_d = '0;
                    quo_d = d_pub;
                    cyc_d = cyc_q + 1'b1;
`ifdef FM_AVG_EN
                    hf_d[2] = hf_q[1];
                    hf_d[1] = hf_q[0];
                    hf_d[0] = f_w;
                    hd_d[2] = hd_q[1];
                    hd_d[1] = hd_q[0];
                    hd_d[0] = d_w;
`endif
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cyc_d = cyc_q + 1'b1;
                    if (cyc_q == DIV_LAST) begin
                        // Last quotient bit: publish now so outputs are valid in DONE.
                        state_d    = S_DONE;
                        mod_freq_d = frq_q;
                        delta_f_d  = dev_q;
                        if (frq_q == '0)        mf_d = 8'd0;
                        else if (quo_nx > 16'd255) mf_d = 8'hFF;
                        else                    mf_d = quo_nx[7:0];
                    end
                end
            end
            S_DONE: begin
                if (bus.cont) begin
                    state_d   = S_ACQ;
                    enter_acq = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_acq) begin
            cyc_d       = '0;
            xcnt_d      = '0;
            armed_d     = 1'b0;
            maxv_d      = 10'd0;
            minv_d      = 10'd1023;
            any_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any measurement in flight.
    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            xcnt_q      <= '0;
            armed_q     <= 1'b0;
            maxv_q      <= '0;
            minv_q      <= 10'd1023;
            any_valid_q <= 1'b0;
            frq_q       <= '0;
            dev_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            mod_freq_q  <= '0;
            delta_f_q   <= '0;
            mf_q        <= '0;
`ifdef FM_AVG_EN
            for (int i = 0; i < 3; i++) begin
                hf_q[i] <= '0;
                hd_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            xcnt_q      <= xcnt_d;
            armed_q     <= armed_d;
            maxv_q      <= maxv_d;
            minv_q      <= minv_d;
            any_valid_q <= any_valid_d;
            frq_q       <= frq_d;
            dev_q       <= dev_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            mod_freq_q  <= mod_freq_d;
            delta_f_q   <= delta_f_d;
            mf_q        <= mf_d;
`ifdef FM_AVG_EN
            for (int i = 0; i < 3; i++) begin
                hf_q[i] <= hf_d[i];
                hd_q[i] <= hd_d[i];
            end
`endif
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.mod_freq     = mod_freq_q;
    assign bus.delta_f      = delta_f_q;
    assign bus.mf           = mf_q;
endmodule
